// File: rtl/dispense_controller_if.sv
// Order, payment and dispense signals between the controller and its neighbours.
interface dispense_controller_if;
  logic        order_valid;
  logic        order_ready;
  logic [1:0]  order_fluid;
  logic [7:0]  order_volume;
  logic [15:0] order_price;
  logic        order_reject;
  logic        coin_valid;
  logic [7:0]  coin_value;
  logic        cancel;
  logic        pump_on;
  logic [1:0]  pump_fluid;
  logic        busy;
  logic [15:0] paid_total;
  logic [7:0]  dispensed_l;
  logic        change_valid;
  logic [15:0] change_amount;
  logic        stock_dec_valid;
  logic [1:0]  stock_dec_fluid;
  logic [7:0]  stock_dec_volume;
  logic        done;
  logic [1:0]  status;

  modport master (
    output order_valid, order_fluid, order_volume, order_price, order_reject,
    output coin_valid, coin_value, cancel,
    input  order_ready, pump_on, pump_fluid, busy, paid_total, dispensed_l,
    input  change_valid, change_amount, stock_dec_valid, stock_dec_fluid,
    input  stock_dec_volume, done, status
  );

  modport slave (
    input  order_valid, order_fluid, order_volume, order_price, order_reject,
    input  coin_valid, coin_value, cancel,
    output order_ready, pump_on, pump_fluid, busy, paid_total, dispensed_l,
    output change_valid, change_amount, stock_dec_valid, stock_dec_fluid,
    output stock_dec_volume, done, status
  );
endinterface

// File: rtl/dispense_controller.sv
// Dispenser back-end: collects payment for a priced order, runs the pump per litre,
// then returns change and reports the stock decrement.
module dispense_controller #(
  parameter int unsigned TICKS_PER_L = 4,
  parameter int unsigned PAY_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  dispense_controller_if.slave  bus
);

  localparam int unsigned TICK_W = (TICKS_PER_L > 1) ? $clog2(TICKS_PER_L) : 1;
  localparam int unsigned TMO_W  = $clog2(PAY_TIMEOUT + 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_REJECT  = 2'b01;
  localparam logic [1:0] ST_CANCEL  = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAY,
    S_DISPENSE,
    S_FINISH,
    S_REFUND
  } state_e;

  state_e              state_q;
  logic [1:0]          fluid_q;
  logic [7:0]          volume_q;
  logic [15:0]         price_q;
  logic [15:0]         paid_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [TICK_W-1:0]   tick_q;
  logic [7:0]          disp_q;

  logic                order_ready_q;
  logic                pump_on_q;
  logic [1:0]          pump_fluid_q;
  logic                busy_q;
  logic                change_valid_q;
  logic [15:0]         change_amount_q;
  logic                stock_dec_valid_q;
  logic [1:0]          stock_dec_fluid_q;
  logic [7:0]          stock_dec_volume_q;
  logic                done_q;
  logic [1:0]          status_q;

  logic [16:0]         paid_sum_c;
  logic [15:0]         paid_d;
  logic [TMO_W-1:0]    tmo_d;
  logic                tmo_hit_c;
  logic                tick_wrap_c;
  logic [7:0]          disp_d;
  logic                order_bad_c;

  // Payment, timeout and litre arithmetic for the current cycle.
  always_comb begin
    paid_sum_c  = {1'b0, paid_q} + {9'd0, bus.coin_value};
    paid_d      = paid_q;
    tmo_d       = tmo_q + TMO_W'(1);
    if (bus.coin_valid) begin
      paid_d = paid_sum_c[16] ? 16'hFFFF : paid_sum_c[15:0];
      tmo_d  = '0;
    end
    tmo_hit_c   = !bus.coin_valid && (tmo_d == TMO_W'(PAY_TIMEOUT));
    tick_wrap_c = (tick_q == TICK_W'(TICKS_PER_L - 1));
    disp_d      = disp_q + 8'd1;
    order_bad_c = bus.order_reject || (bus.order_volume == 8'd0) ||
                  (bus.order_fluid == 2'b11);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= S_IDLE;
      fluid_q            <= '0;
      volume_q           <= '0;
      price_q            <= '0;
      paid_q             <= '0;
      tmo_q              <= '0;
      tick_q             <= '0;
      disp_q             <= '0;
      order_ready_q      <= 1'b1;
      pump_on_q          <= 1'b0;
      pump_fluid_q       <= '0;
      busy_q             <= 1'b0;
      change_valid_q     <= 1'b0;
      change_amount_q    <= '0;
      stock_dec_valid_q  <= 1'b0;
      stock_dec_fluid_q  <= '0;
      stock_dec_volume_q <= '0;
      done_q             <= 1'b0;
      status_q           <= '0;
    end else begin
      done_q            <= 1'b0;
      change_valid_q    <= 1'b0;
      stock_dec_valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (bus.order_valid && order_ready_q) begin
            if (order_bad_c) begin
              done_q   <= 1'b1;
              status_q <= ST_REJECT;
            end else begin
              fluid_q       <= bus.order_fluid;
              volume_q      <= bus.order_volume;
              price_q       <= bus.order_price;
              paid_q        <= '0;
              tmo_q         <= '0;
              tick_q        <= '0;
              disp_q        <= '0;
              busy_q        <= 1'b1;
              order_ready_q <= 1'b0;
              state_q       <= S_PAY;
            end
          end
        end

        // Cancel beats timeout beats price covered; a same-cycle coin is still counted.
        S_PAY: begin
          paid_q <= paid_d;
          tmo_q  <= tmo_d;
          if (bus.cancel || tmo_hit_c) begin
            change_valid_q  <= 1'b1;
            change_amount_q <= paid_d;
            done_q          <= 1'b1;
            status_q        <= bus.cancel ? ST_CANCEL : ST_TIMEOUT;
            state_q         <= S_REFUND;
          end else if (paid_d >= price_q) begin
            pump_on_q    <= 1'b1;
            pump_fluid_q <= fluid_q;
            tick_q       <= '0;
            state_q      <= S_DISPENSE;
          end
        end

        S_DISPENSE: begin
          if (tick_wrap_c) begin
            tick_q <= '0;
            disp_q <= disp_d;
            if (disp_d == volume_q) begin
              pump_on_q          <= 1'b0;
              change_valid_q     <= 1'b1;
              change_amount_q    <= paid_q - price_q;
              stock_dec_valid_q  <= 1'b1;
              stock_dec_fluid_q  <= fluid_q;
              stock_dec_volume_q <= volume_q;
              done_q             <= 1'b1;
              status_q           <= ST_OK;
              state_q            <= S_FINISH;
            end
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
        end

        S_FINISH, S_REFUND: begin
          busy_q        <= 1'b0;
          order_ready_q <= 1'b1;
          state_q       <= S_IDLE;
        end

        default: begin
          busy_q        <= 1'b0;
          order_ready_q <= 1'b1;
          pump_on_q     <= 1'b0;
          state_q       <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.order_ready      = order_ready_q;
  assign bus.pump_on          = pump_on_q;
  assign bus.pump_fluid       = pump_fluid_q;
  assign bus.busy             = busy_q;
  assign bus.paid_total       = paid_q;
  assign bus.dispensed_l      = disp_q;
  assign bus.change_valid     = change_valid_q;
  assign bus.change_amount    = change_amount_q;
  assign bus.stock_dec_valid  = stock_dec_valid_q;
  assign bus.stock_dec_fluid  = stock_dec_fluid_q;
  assign bus.stock_dec_volume = stock_dec_volume_q;
  assign bus.done             = done_q;
  assign bus.status           = status_q;

endmodule

// File: tb/tb_dispense_controller.sv
// Directed bench for dispense_controller with TICKS_PER_L=4 and PAY_TIMEOUT=8.
module tb_dispense_controller;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   npump;

  dispense_controller_if bus ();

  dispense_controller #(
    .TICKS_PER_L (4),
    .PAY_TIMEOUT (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [1:0] fl, input logic [7:0] vol,
                       input logic [15:0] price, input logic rej);
    bus.order_valid  = 1'b1;
    bus.order_fluid  = fl;
    bus.order_volume = vol;
    bus.order_price  = price;
    bus.order_reject = rej;
    step();
    bus.order_valid  = 1'b0;
    bus.order_reject = 1'b0;
  endtask

  task automatic coin(input logic [7:0] val);
    bus.coin_valid = 1'b1;
    bus.coin_value = val;
    step();
    bus.coin_valid = 1'b0;
    bus.coin_value = 8'd0;
  endtask

  // Counts pump cycles, stopping at the first pump-off cycle or after 40 cycles.
  task automatic count_pump(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.pump_on) break;
      n++;
      step();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.order_valid = 1'b0; bus.order_fluid = 2'd0; bus.order_volume = 8'd0;
    bus.order_price = 16'd0; bus.order_reject = 1'b0;
    bus.coin_valid = 1'b0; bus.coin_value = 8'd0; bus.cancel = 1'b0;
    step(); step();
    chk("rst_ready", 32'(bus.order_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_pump", 32'(bus.pump_on), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_status", 32'(bus.status), 0);
    chk("rst_paid", 32'(bus.paid_total), 0);
    reset_n = 1'b1;
    step();

    // Water, 3 L, price 40, two coins of 20.
    offer(2'd0, 8'd3, 16'd40, 1'b0);
    chk("w_busy", 32'(bus.busy), 1);
    chk("w_ready", 32'(bus.order_ready), 0);
    coin(8'd20);
    chk("w_paid1", 32'(bus.paid_total), 20);
    chk("w_pump_early", 32'(bus.pump_on), 0);
    coin(8'd20);
    chk("w_pump_on", 32'(bus.pump_on), 1);
    chk("w_pump_fluid", 32'(bus.pump_fluid), 0);
    chk("w_paid2", 32'(bus.paid_total), 40);
    count_pump(npump);
    chk("w_pump_cycles", 32'(npump), 12);
    chk("w_chg_valid", 32'(bus.change_valid), 1);
    chk("w_chg_amt", 32'(bus.change_amount), 0);
    chk("w_sdec_valid", 32'(bus.stock_dec_valid), 1);
    chk("w_sdec_fluid", 32'(bus.stock_dec_fluid), 0);
    chk("w_sdec_vol", 32'(bus.stock_dec_volume), 3);
    chk("w_done", 32'(bus.done), 1);
    chk("w_status", 32'(bus.status), 0);
    step();
    chk("w_ready_back", 32'(bus.order_ready), 1);
    chk("w_done_pulse", 32'(bus.done), 0);
    chk("w_chg_pulse", 32'(bus.change_valid), 0);

    // Juice, 2 L, price 80, coins 50+50: change 20.
    offer(2'd1, 8'd2, 16'd80, 1'b0);
    coin(8'd50);
    coin(8'd50);
    chk("j_pump_fluid", 32'(bus.pump_fluid), 1);
    count_pump(npump);
    chk("j_pump_cycles", 32'(npump), 8);
    chk("j_chg_amt", 32'(bus.change_amount), 20);
    chk("j_disp", 32'(bus.dispensed_l), 2);
    chk("j_sdec_fluid", 32'(bus.stock_dec_fluid), 1);
    chk("j_sdec_vol", 32'(bus.stock_dec_volume), 2);
    step();

    // Rejected orders: stock flag, illegal fluid, zero volume.
    offer(2'd0, 8'd1, 16'd5, 1'b1);
    chk("r1_done", 32'(bus.done), 1);
    chk("r1_status", 32'(bus.status), 1);
    chk("r1_ready", 32'(bus.order_ready), 1);
    chk("r1_busy", 32'(bus.busy), 0);
    step();
    chk("r1_done_pulse", 32'(bus.done), 0);
    chk("r1_status_held", 32'(bus.status), 1);
    chk("r1_pump", 32'(bus.pump_on), 0);
    offer(2'd3, 8'd1, 16'd5, 1'b0);
    chk("r2_done", 32'(bus.done), 1);
    chk("r2_busy", 32'(bus.busy), 0);
    step();
    offer(2'd1, 8'd0, 16'd5, 1'b0);
    chk("r3_done", 32'(bus.done), 1);
    chk("r3_ready", 32'(bus.order_ready), 1);
    step();
    chk("r3_pump", 32'(bus.pump_on), 0);

    // Coin 10, then cancel together with coin 5: refund 15.
    offer(2'd1, 8'd1, 16'd100, 1'b0);
    coin(8'd10);
    bus.cancel = 1'b1;
    coin(8'd5);
    bus.cancel = 1'b0;
    chk("c_chg_valid", 32'(bus.change_valid), 1);
    chk("c_chg_amt", 32'(bus.change_amount), 15);
    chk("c_status", 32'(bus.status), 2);
    chk("c_done", 32'(bus.done), 1);
    chk("c_sdec", 32'(bus.stock_dec_valid), 0);
    chk("c_pump", 32'(bus.pump_on), 0);
    step();
    chk("c_ready_back", 32'(bus.order_ready), 1);

    // Timeout with no coins: refund in the 9th cycle after accept.
    offer(2'd0, 8'd1, 16'd50, 1'b0);
    for (int i = 0; i < 7; i++) step();
    chk("t1_still_pay", 32'(bus.busy), 1);
    chk("t1_no_chg", 32'(bus.change_valid), 0);
    step();
    chk("t1_chg_valid", 32'(bus.change_valid), 1);
    chk("t1_chg_amt", 32'(bus.change_amount), 0);
    chk("t1_status", 32'(bus.status), 3);
    chk("t1_done", 32'(bus.done), 1);
    step();

    // Timeout restarted by a coin in PAY cycle 5.
    offer(2'd0, 8'd1, 16'd50, 1'b0);
    for (int i = 0; i < 4; i++) step();
    coin(8'd3);
    for (int i = 0; i < 7; i++) step();
    chk("t2_still_pay", 32'(bus.busy), 1);
    chk("t2_no_chg", 32'(bus.change_valid), 0);
    step();
    chk("t2_chg_valid", 32'(bus.change_valid), 1);
    chk("t2_chg_amt", 32'(bus.change_amount), 3);
    chk("t2_status", 32'(bus.status), 3);
    step();

    // Reset during dispense at litre 1 of 3.
    offer(2'd0, 8'd3, 16'd10, 1'b0);
    coin(8'd10);
    for (int i = 0; i < 4; i++) step();
    chk("x_disp1", 32'(bus.dispensed_l), 1);
    chk("x_pumping", 32'(bus.pump_on), 1);
    reset_n = 1'b0;
    #1;
    chk("x_pump_off", 32'(bus.pump_on), 0);
    chk("x_ready", 32'(bus.order_ready), 1);
    chk("x_busy", 32'(bus.busy), 0);
    chk("x_disp0", 32'(bus.dispensed_l), 0);
    chk("x_paid0", 32'(bus.paid_total), 0);
    chk("x_status", 32'(bus.status), 0);
    step(); step();
    chk("x_no_chg", 32'(bus.change_valid), 0);
    chk("x_no_sdec", 32'(bus.stock_dec_valid), 0);
    reset_n = 1'b1;
    step();

    // Zero-price juice after reset: pumps with no coins, one litre.
    offer(2'd1, 8'd1, 16'd0, 1'b0);
    chk("z_busy", 32'(bus.busy), 1);
    chk("z_pump_early", 32'(bus.pump_on), 0);
    step();
    count_pump(npump);
    chk("z_pump_cycles", 32'(npump), 4);
    chk("z_chg_amt", 32'(bus.change_amount), 0);
    chk("z_sdec_valid", 32'(bus.stock_dec_valid), 1);
    chk("z_sdec_fluid", 32'(bus.stock_dec_fluid), 1);
    chk("z_sdec_vol", 32'(bus.stock_dec_volume), 1);
    step();
    chk("z_ready_back", 32'(bus.order_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dispense_controller.md
# dispense_controller

Sequential back-end of the dispenser. It takes a priced order (fluid, litres, discounted final price, stock verdict) from the pricing/stock stage, collects coins until the price is covered, and runs the pump for a fixed number of cycles per litre. It then returns change and emits a stock-decrement pulse that the stock bookkeeping consumes.

## Interface
- TICKS_PER_L, default 4: clock cycles of pump_on per litre; legal range ≥1.
- PAY_TIMEOUT, default 255: consecutive coin-free cycles in PAY before the order is abandoned; legal range ≥1.
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- order_valid  in  1  order offered.
- order_ready  out  1  high only in IDLE.
- order_fluid  in  2  00 water, 01 juice, 10 chemical, 11 illegal.
- order_volume  in  8  litres.
- order_price  in  16  final (discounted) price.
- order_reject  in  1  stock stage flagged insufficient stock.
- coin_valid  in  1  one coin this cycle.
- coin_value  in  8  coin amount.
- cancel  in  1  user abort.
- pump_on  out  1  pump drive.
- pump_fluid  out  2  latched fluid for the valve.
- busy  out  1  state ≠ IDLE.
- paid_total  out  16  accumulated payment.
- dispensed_l  out  8  litres completed in the current order.
- change_valid  out  1  one-cycle pulse.
- change_amount  out  16  valid with change_valid.
- stock_dec_valid  out  1  one-cycle pulse.
- stock_dec_fluid  out  2  valid with stock_dec_valid.
- stock_dec_volume  out  8  valid with stock_dec_valid.
- done  out  1  one-cycle pulse at the end of every accepted order.
- status  out  2  00 ok, 01 rejected, 10 cancelled, 11 timeout; held until the next done.

## Operation
States: IDLE, PAY, DISPENSE, FINISH, REFUND. All outputs are registered.

- **Reset:** state IDLE, order_ready=1, every other output and internal register 0.
- **IDLE:** an order is accepted on a clk edge with order_valid=1 and order_ready=1.
  - If order_reject=1, order_volume=0 or order_fluid=11: done=1 and status=01 in the next cycle; FSM stays in IDLE.
  - Otherwise: latch fluid, volume and price; clear paid_total, the timeout counter and dispensed_l; go to PAY.
- **PAY:**
  - coin_valid adds coin_value to paid_total, saturating at 16'hFFFF, and clears the timeout counter.
  - A cycle without a coin increments the timeout counter.
  - Priority, highest first:
    1. cancel → REFUND with status 10. A coin in the same cycle is still added and refunded.
    2. Timeout counter reaches PAY_TIMEOUT → REFUND with status 11.
    3. Updated paid_total ≥ price → DISPENSE.
- **DISPENSE:**
  - pump_on=1; pump_fluid = latched fluid.
  - A tick counter counts 0..TICKS_PER_L−1. On wrap, dispensed_l increments.
  - When dispensed_l reaches the latched volume → FINISH.
  - cancel and coins are ignored; coins are not accumulated outside PAY.
- **FINISH** (one cycle):
  - change_valid=1, change_amount = paid_total − price.
  - stock_dec_valid=1 with the latched fluid and volume.
  - done=1, status=00; then go to IDLE.
- **REFUND** (one cycle):
  - change_valid=1, change_amount = paid_total. The pulse is issued even when the amount is 0.
  - No stock_dec_valid; done=1; then go to IDLE.
- **Arithmetic:** all additions and subtractions are unsigned 16-bit. The change subtraction cannot underflow because FINISH is reached only with paid_total ≥ price.
- **Mid-operation reset:** asserting reset_n drops pump_on immediately (asynchronous). No change_valid or stock_dec_valid is issued for the aborted order.

## Timing
- Accept at edge k → busy=1 and state PAY in cycle k+1. For a rejected order, done/status are valid in cycle k+1.
- Covering coin sampled at edge m → pump_on=1 from cycle m+1.
- pump_on stays high for exactly volume×TICKS_PER_L cycles, then FINISH follows for one cycle with no gap.
- order_ready returns high in the cycle after FINISH or REFUND, so back-to-back orders are possible every (order length + 1) cycles.
- Timeout: after the last coin (or after entry into PAY), PAY_TIMEOUT coin-free cycles → REFUND in the next cycle.

## Test plan
- Water, volume 3, price 40, coins 20 then 20 → DISPENSE the cycle after the second coin; pump_on high 12 cycles; change 0; stock_dec (00, 3); status 00.
- Juice, volume 2, price 80, coins 50, 50 → change_amount 20; dispensed_l ends at 2; stock_dec (01, 2).
- order_reject=1 (also order_fluid=11, and volume=0 in separate runs) → done, status 01 the next cycle; pump_on never set; order_ready stays high.
- Coin 10, then cancel together with coin 5 → REFUND, change 15, status 10, no stock_dec.
- PAY_TIMEOUT=8, no coins → REFUND after 8 PAY cycles, change_valid with amount 0, status 11. Repeat with a coin at cycle 5 to confirm the counter restarts.
- reset_n low during DISPENSE, at litre 1 of 3 → pump_on 0 immediately and all outputs at reset values. After release, a new order is accepted normally.
